// File: rtl/cla_pipe_addsub_if.sv
// Operand/result bus for the pipelined carry-lookahead adder/subtractor.
// The slave side is the adder; the master side is the operand source plus
// result consumer.
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             of;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, of
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, of
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined two's-complement adder/subtractor. The carry chain is cut into
// STAGES registered slices of WIDTH/STAGES bits, each built from 4-bit CLA
// groups. Stage k consumes the still-unprocessed upper operand bits delayed
// by the previous stage and hands its carry to stage k+1.
//
// Handshake (valid/ready): a beat moves on an edge where valid && ready are
// both 1. en = !out_valid || out_ready; the whole pipe advances only when en=1
// (global stall, bubbles are not collapsed). in_ready = en && !rst. While the
// output is stalled, sum/cout/of/out_valid hold.
module cla_pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    cla_pipe_addsub_if.slave   bus
);
    localparam int S      = WIDTH / STAGES;
    localparam int GROUPS = S / 4;

    // 4-bit lookahead group: returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       grp_g;
        logic       grp_p;
        g     = x & y;
        p     = x ^ y;
        c[0]  = ci;
        c[1]  = g[0] | (p[0] & ci);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        grp_p = &p;
        return {grp_g | (grp_p & ci), p ^ c};
    endfunction

    logic en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * S;

        logic [WIDTH-1:LO]  a_in;
        logic [WIDTH-1:LO]  bx_in;
        logic               c_in;
        logic               v_in;
        logic [S-1:0]       slice_sum;
        logic [GROUPS:0]    gc;
        logic [4:0]         grp;
        logic [LO+S-1:0]    sum_d;
        logic [LO+S-1:0]    sum_q;
        logic               carry_d;
        logic               carry_q;
        logic               valid_d;
        logic               valid_q;

        if (k == 0) begin : g_src
            // Condition operands: subtract is A + ~B + ~cin.
            always_comb begin
                a_in    = bus.a;
                bx_in   = bus.sub ? ~bus.b : bus.b;
                c_in    = bus.sub ? ~bus.cin : bus.cin;
                v_in    = bus.in_valid;
                sum_d   = slice_sum;
            end
        end else begin : g_chain
            // Pick up delayed operands, carry and partial sum from the previous slice.
            always_comb begin
                a_in    = g_stage[k-1].g_fwd.a_q;
                bx_in   = g_stage[k-1].g_fwd.bx_q;
                c_in    = g_stage[k-1].carry_q;
                v_in    = g_stage[k-1].valid_q;
                sum_d   = {slice_sum, g_stage[k-1].sum_q};
            end
        end

        // Add this slice with a chain of 4-bit lookahead groups.
        always_comb begin
            gc        = '0;
            grp       = '0;
            slice_sum = '0;
            gc[0]     = c_in;
            for (int j = 0; j < GROUPS; j++) begin
                grp                  = cla4(a_in[LO+j*4 +: 4], bx_in[LO+j*4 +: 4], gc[j]);
                slice_sum[j*4 +: 4]  = grp[3:0];
                gc[j+1]              = grp[4];
            end
            carry_d = gc[GROUPS];
            valid_d = v_in;
        end

        // Slice result registers; advance only on en, cleared by reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else if (en) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
                valid_q <= valid_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:LO+S] a_d;
            logic [WIDTH-1:LO+S] a_q;
            logic [WIDTH-1:LO+S] bx_d;
            logic [WIDTH-1:LO+S] bx_q;

            // Only the bits later slices still need are carried forward.
            always_comb begin
                a_d  = a_in[WIDTH-1:LO+S];
                bx_d = bx_in[WIDTH-1:LO+S];
            end

            // Delay line for the unprocessed upper operand bits.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q  <= '0;
                    bx_q <= '0;
                end else if (en) begin
                    a_q  <= a_d;
                    bx_q <= bx_d;
                end
            end
        end else begin : g_last
            logic of_d;
            logic of_q;

            // Overflow: conditioned operand signs agree but the result sign differs.
            always_comb begin
                of_d = (a_in[WIDTH-1] == bx_in[WIDTH-1]) && (slice_sum[S-1] != a_in[WIDTH-1]);
            end

            // Overflow flag register, aligned with the final slice.
            always_ff @(posedge clk) begin
                if (rst) begin
                    of_q <= 1'b0;
                end else if (en) begin
                    of_q <= of_d;
                end
            end
        end
    end

    assign en            = !g_stage[STAGES-1].valid_q || bus.out_ready;
    assign bus.in_ready  = en && !rst;
    assign bus.out_valid = g_stage[STAGES-1].valid_q;
    assign bus.sum       = g_stage[STAGES-1].sum_q;
    assign bus.cout      = g_stage[STAGES-1].carry_q;
    assign bus.of        = g_stage[STAGES-1].g_last.of_q;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: a 32-bit/2-stage instance checked every cycle
// against an arithmetic model through an expected queue, and a 16-bit/4-stage
// instance checked with directed and model-derived beats.
module tb_cla_pipe_addsub;
    localparam int W   = 32;
    localparam int ST  = 2;
    localparam int W2  = 16;
    localparam int ST2 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cla_pipe_addsub_if #(.WIDTH(W))  bus();
    cla_pipe_addsub_if #(.WIDTH(W2)) bus16();

    cla_pipe_addsub #(.WIDTH(W), .STAGES(ST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cla_pipe_addsub #(.WIDTH(W2), .STAGES(ST2)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    int checks   = 0;
    int failures = 0;
    logic [W+1:0] exp_q[$];
    int stall_cnt  = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Plain integer arithmetic: returns {of, cout, sum} for a w-bit operation.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        longint m, ua, ub, sa, sb, us, ss, ci;
        logic c, o;
        logic [31:0] r;
        m  = longint'(1) << w;
        ua = longint'({32'd0, a}) & (m - 1);
        ub = longint'({32'd0, b}) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        ci = cin ? 1 : 0;
        if (!sub) begin
            us = ua + ub + ci;
            ss = sa + sb + ci;
            c  = (us >= m);
        end else begin
            us = ua - ub - ci;
            ss = sa - sb - ci;
            c  = (us >= 0);
        end
        o = (ss < -(m / 2)) || (ss >= m / 2);
        r = 32'(us & (m - 1));
        return {o, c, r};
    endfunction

    // Scoreboard: compare every valid output slot with the queue front.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            check("in_ready_in_reset", 64'(bus.in_ready), 64'd0);
        end else begin
            check("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %h expected no valid output",
                             {bus.of, bus.cout, bus.sum});
                end else begin
                    check("result", 64'({bus.of, bus.cout, bus.sum}), 64'(exp_q[0]));
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(W, bus.a, bus.b, bus.cin, bus.sub));
        end
    end

    // Consumer back-pressure: forced stalls, optional random ready, else always ready.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (stall_cnt > 0) begin
                bus.out_ready = 1'b0;
                stall_cnt--;
            end else if (rand_ready) begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat and hold it until accepted; in_valid is left high so
    // consecutive calls stream back-to-back.
    task automatic drive_beat(input logic [31:0] a, input logic [31:0] b,
                              input logic cin, input logic sub);
        bit acc;
        acc          = 1'b0;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL drive_timeout: in_ready stayed 0, expected 1 within 100 cycles");
        end
    endtask

    // Single beat into an idle 32-bit pipe: check latency and a hand value.
    task automatic directed32(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic cin, input logic sub, input logic [W+1:0] lit);
        int n;
        bit seen;
        n            = 0;
        seen         = 1'b0;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            n++;
            @(negedge clk);
            seen = bus.out_valid;
        end
        check({name, "_latency"}, 64'(n), 64'(ST));
        check({name, "_value"}, 64'({bus.of, bus.cout, bus.sum}), 64'(lit));
        @(posedge clk);
        #1;
    endtask

    // Single beat into the 16-bit/4-stage pipe.
    task automatic directed16(input string name, input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic sub, input logic [17:0] expv);
        int n;
        bit seen;
        n              = 0;
        seen           = 1'b0;
        bus16.a        = a;
        bus16.b        = b;
        bus16.cin      = cin;
        bus16.sub      = sub;
        bus16.in_valid = 1'b1;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            bus16.in_valid = 1'b0;
            n++;
            @(negedge clk);
            seen = bus16.out_valid;
        end
        check({name, "_latency"}, 64'(n), 64'(ST2));
        check({name, "_value"}, 64'({bus16.of, bus16.cout, bus16.sum}), 64'(expv));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] m;
        logic [15:0] ra, rb;
        logic        rc, rs;
        int          guard;

        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.cin        = 1'b0;
        bus.sub        = 1'b0;
        bus.out_ready  = 1'b1;
        bus16.in_valid = 1'b0;
        bus16.a        = '0;
        bus16.b        = '0;
        bus16.cin      = 1'b0;
        bus16.sub      = 1'b0;
        bus16.out_ready = 1'b1;

        // Clock/reset block.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_sum", 64'(bus.sum), 64'd0);
        check("reset_cout", 64'(bus.cout), 64'd0);
        check("reset_of", 64'(bus.of), 64'd0);
        check("reset_out_valid16", 64'(bus16.out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Directed add/subtract vectors with hand-computed results.
        directed32("add_pos_of",   32'h7fffffff, 32'h7fffffff, 1'b0, 1'b0, {2'b10, 32'hfffffffe});
        directed32("add_neg_of",   32'h80000000, 32'hffffffff, 1'b0, 1'b0, {2'b11, 32'h7fffffff});
        directed32("add_carry",    32'hffffffff, 32'hffffffff, 1'b0, 1'b0, {2'b01, 32'hfffffffe});
        directed32("sub_borrow",   32'h00000005, 32'h00000007, 1'b0, 1'b1, {2'b00, 32'hfffffffe});
        directed32("sub_of",       32'h80000000, 32'h00000001, 1'b0, 1'b1, {2'b11, 32'h7fffffff});
        directed32("sub_cin",      32'h12345678, 32'h12345670, 1'b1, 1'b1, {2'b01, 32'h00000007});
        directed32("sub_zero",     32'h00000000, 32'h00000000, 1'b0, 1'b1, {2'b01, 32'h00000000});
        directed32("sub_zero_bin", 32'h00000000, 32'h00000000, 1'b1, 1'b1, {2'b00, 32'hffffffff});
        directed32("add_cin_wrap", 32'hffffffff, 32'h00000000, 1'b1, 1'b0, {2'b01, 32'h00000000});

        // Back-to-back stream with a 3-cycle consumer stall in the middle.
        for (int i = 0; i < 8; i++) begin
            if (i == 4) stall_cnt = 3;
            drive_beat(32'(i), 32'(i), i[0], 1'b0);
        end
        idle(8);
        check("stream_drained", 64'(exp_q.size()), 64'd0);

        // Reset with two beats in flight: both must vanish.
        stall_cnt = 6;
        idle(1);
        drive_beat(32'h11111111, 32'h22222222, 1'b0, 1'b0);
        drive_beat(32'h33333333, 32'h44444444, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall_cnt = 0;
        @(negedge clk);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_sum", 64'(bus.sum), 64'd0);
        @(posedge clk);
        #1;
        idle(2);
        directed32("after_reset", 32'h00000123, 32'h00000123, 1'b0, 1'b0, {2'b00, 32'h00000246});

        // Parametric instance: hand vector then model-derived vectors.
        directed16("w16_lit", 16'hfa99, 16'h0111, 1'b1, 1'b0, {2'b00, 16'hfbab});
        directed16("w16_sub_of", 16'h8000, 16'h0001, 1'b0, 1'b1, {2'b11, 16'h7fff});
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            m  = model(W2, {16'd0, ra}, {16'd0, rb}, rc, rs);
            directed16("w16_rand", ra, rb, rc, rs, {m[33], m[32], m[15:0]});
        end

        // Random beats with random gaps and random consumer ready.
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            drive_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        bus.in_valid = 1'b0;
        rand_ready = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        check("random_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined successor to the 32-bit combinational carry-lookahead adder.
- Adds or subtracts two WIDTH-bit two's-complement operands.
- Carry chain split into STAGES registered slices, each slice built from 4-bit CLA groups.
- Valid/ready handshake on input and output; sits between operand source and result consumer in the adder datapath of the chip.

Parameters:
- WIDTH, 32, operand/result width; multiple of 4*STAGES.
- STAGES, 2, number of pipeline slices (1..8); each slice handles WIDTH/STAGES bits; latency = STAGES cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = A+B+cin, 1 = A-B-cin.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of MSB (sub: 1 = no borrow).
- of  out  1  signed overflow.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset: sum=0, cout=0, of=0, out_valid=0, all stage valid bits and carries cleared; in_ready=0 while rst=1.
- Reset mid-operation: all in-flight beats are discarded, with no partial output.
- Operand conditioning at input:
  - bx = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
  - A-B-cin is therefore computed as A + ~B + (1-cin).
- Stage k (0..STAGES-1):
  - Adds bits [k*S +: S] (S = WIDTH/STAGES) of A and bx with the carry from stage k-1 (c0 for k=0).
  - Uses 4-bit group generate/propagate lookahead within the slice.
  - Registers the partial sum, carry-out, a slice valid bit, and delayed copies of the upper operand bits still unprocessed.
- Final stage: cout = carry out of bit WIDTH-1; of = carry into MSB XOR carry out of MSB (equivalently, operand signs equal and result sign differs, after conditioning).
- Handshake:
  - en = !out_valid || out_ready.
  - in_ready = en && !rst.
  - All pipeline registers advance only when en=1; otherwise the whole pipe holds (global stall, no bubble collapse).
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
- Latency: an accepted beat appears on out_valid exactly STAGES enabled cycles later. Throughput is 1 beat/cycle while out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, sum/cout/of/out_valid hold constant. Inputs are ignored while in_ready=0.
- Simultaneous accept and consume in one cycle are both allowed; the pipe shifts by one.
- Bubbles: in_valid=0 while en=1 inserts an invalid slot that propagates as out_valid=0.
- STAGES=1: purely registered single-cycle adder with the same handshake.
- Modular arithmetic: sum wraps mod 2^WIDTH; there is no saturation.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1: a=7fffffff, b=7fffffff, cin=0, sub=0 -> 2 cycles later sum=fffffffe, cout=0, of=1, out_valid=1.
- Add with carry-out and overflow: a=80000000, b=ffffffff, cin=0, sub=0 -> sum=7fffffff, cout=1, of=1. Then a=ffffffff, b=ffffffff -> sum=fffffffe, cout=1, of=0.
- Subtract:
  - a=00000005, b=00000007, sub=1, cin=0 -> sum=fffffffe, cout=0, of=0.
  - a=80000000, b=00000001, sub=1 -> sum=7fffffff, cout=1, of=1.
  - a=12345678, b=12345670, sub=1, cin=1 -> sum=00000007, cout=1, of=0.
- Back-to-back and stall:
  - Stream 8 beats (a=i, b=i, cin=i[0]) with out_ready=1 -> results 2i+i[0] in order on consecutive cycles.
  - Drop out_ready for 3 cycles mid-stream -> in_ready=0, outputs frozen, no beat lost or duplicated; in order after release.
- Reset mid-stream: assert rst for 1 cycle with 2 beats in flight -> next cycle out_valid=0, sum=0; the flushed beats never appear; new beat 0x123+0x123 yields 0x246 after 2 cycles.
- Parametric: WIDTH=16, STAGES=4, a=fa99, b=0111, cin=1 -> 4 cycles later sum=fbab, cout=0, of=0. Random 1000-beat comparison against a behavioural model with random out_ready.
